rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/loader_pkg.sv | 17 +
 rtl/rom_loader.sv | 152 +++++++++++++++
 tb/tb_rom_loader.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the CPU ROM loader: state encoding and default
// strobe/gap timing.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_BYTE = 3'd1,
        S_SETUP     = 3'd2,
        S_STROBE    = 3'd3,
        S_GAP       = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    localparam int DEF_SEND_HOLD = 1;
    localparam int DEF_GAP       = 1;

endpackage

// File: rtl/rom_loader.sv
// Streams bytes into a CPU ROM edit port: one SETUP cycle, a SEND_HOLD-cycle
// write strobe and a GAP-cycle recovery per byte, optionally raising run at the end.
module rom_loader
    import loader_pkg::*;
#(
    parameter int SEND_HOLD = DEF_SEND_HOLD,
    parameter int GAP       = DEF_GAP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] base,
    input  logic [7:0] len,
    input  logic       auto_run,
    input  logic       abort,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       edit,
    output logic [7:0] unit,
    output logic [7:0] code,
    output logic       send,
    output logic       run,
    output logic       busy,
    output logic       done,
    output state_t     dbg_state
);

    // Handshake: a byte moves when in_valid and in_ready are both high on a
    // rising edge; in_ready is high only in WAIT_BYTE and never depends on in_valid.

    localparam logic [3:0] HOLD_LOAD = 4'(SEND_HOLD - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP - 1);

    state_t     state, state_nxt;
    logic [7:0] count;
    logic [7:0] len_q;
    logic       auto_q;
    logic [3:0] tmr;
    logic       hs;
    logic       last_byte;
    logic       aborting;

    assign hs        = in_valid && (state == S_WAIT_BYTE);
    assign last_byte = ((count + 8'd1) == len_q);
    assign aborting  = abort && (state != S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len != 8'd0) ? S_WAIT_BYTE : S_FINISH;
                end
            end
            S_WAIT_BYTE: if (hs) state_nxt = S_SETUP;
            S_SETUP:     state_nxt = S_STROBE;
            S_STROBE:    if (tmr == 4'd0) state_nxt = S_GAP;
            S_GAP: begin
                if (tmr == 4'd0) begin
                    state_nxt = last_byte ? S_FINISH : S_WAIT_BYTE;
                end
            end
            S_FINISH:    state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if (aborting) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        in_ready = 1'b0;
        edit     = 1'b0;
        send     = 1'b0;
        busy     = (state != S_IDLE);
        done     = 1'b0;
        case (state)
            S_WAIT_BYTE: begin
                in_ready = 1'b1;
                edit     = 1'b1;
            end
            S_SETUP:  edit = 1'b1;
            S_STROBE: begin
                edit = 1'b1;
                send = 1'b1;
            end
            S_GAP:    edit = 1'b1;
            S_FINISH: done = 1'b1;
            default:  ;
        endcase
    end

    // One down-counter times both the strobe and the gap; it is reloaded on
    // each phase entry so it always reads zero on the phase's final cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unit   <= 8'd0;
            code   <= 8'd0;
            count  <= 8'd0;
            len_q  <= 8'd0;
            auto_q <= 1'b0;
            run    <= 1'b0;
            tmr    <= 4'd0;
        end else if (aborting) begin
            tmr <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        unit   <= base;
                        len_q  <= len;
                        auto_q <= auto_run;
                        count  <= 8'd0;
                        run    <= 1'b0;
                    end
                end
                S_WAIT_BYTE: if (hs) code <= in_data;
                S_SETUP:     tmr <= HOLD_LOAD;
                S_STROBE: begin
                    if (tmr == 4'd0) begin
                        tmr <= GAP_LOAD;
                    end else begin
                        tmr <= tmr - 4'd1;
                    end
                end
                S_GAP: begin
                    if (tmr != 4'd0) begin
                        tmr <= tmr - 4'd1;
                    end else begin
                        count <= count + 8'd1;
                        if (!last_byte) begin
                            unit <= unit + 8'd1;
                        end
                    end
                end
                S_FINISH:    run <= auto_q;
                default:     ;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: expected (unit, code) writes are queued as
// bytes are offered and checked by negedge monitors when send rises.
module tb_rom_loader;
    import loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, auto_run, abort, in_valid;
    logic [7:0] base, len, in_data;
    logic       in_ready, edit, send, run, busy, done;
    logic [7:0] unit, code;
    state_t     dbg_state;

    logic       b_start, b_auto_run, b_abort, b_in_valid;
    logic [7:0] b_base, b_len, b_in_data;
    logic       b_in_ready, b_edit, b_send, b_run, b_busy, b_done;
    logic [7:0] b_unit, b_code;
    state_t     b_dbg_state;

    rom_loader dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
        .auto_run(auto_run), .abort(abort), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .edit(edit), .unit(unit), .code(code), .send(send),
        .run(run), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    rom_loader #(.SEND_HOLD(3), .GAP(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .base(b_base), .len(b_len),
        .auto_run(b_auto_run), .abort(b_abort), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .edit(b_edit), .unit(b_unit), .code(b_code), .send(b_send),
        .run(b_run), .busy(b_busy), .done(b_done), .dbg_state(b_dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard / monitor for the default-timing DUT
    logic [15:0] exp_q[$];
    logic [7:0]  exp_unit;
    logic        send_q = 1'b0;
    int hold = 0, rises = 0, last_rise = 0, prev_rise = 0, hs_cyc = -100;
    int done_cnt = 0, edit_cnt = 0, rdy_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (send && !send_q) begin
                logic [15:0] e;
                rises++;
                prev_rise = last_rise;
                last_rise = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_send", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("unit", int'(unit), int'(e[15:8]));
                    check("code", int'(code), int'(e[7:0]));
                end
                check("send_latency", cyc - hs_cyc, 2);
                hold = 1;
            end else if (send) begin
                hold++;
            end
            if (!send && send_q) check("send_hold", hold, 1);
            if (in_valid && in_ready) hs_cyc = cyc;
            if (done) done_cnt++;
            if (edit) edit_cnt++;
            if (in_ready) rdy_cnt++;
        end
        send_q = rst ? 1'b0 : send;
    end

    // ---------------- scoreboard / monitor for the SEND_HOLD=3, GAP=2 DUT
    logic [15:0] b_exp_q[$];
    logic        b_send_q = 1'b0, b_rdy_q = 1'b0, b_fall_seen = 1'b0;
    logic [7:0]  b_unit_q, b_code_q;
    state_t      b_state_q = S_IDLE;
    int b_hold = 0, b_fall_cyc = 0, b_done_cnt = 0;

    function automatic logic in_write(input state_t s);
        return (s == S_SETUP) || (s == S_STROBE) || (s == S_GAP);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (b_send && !b_send_q) begin
                logic [15:0] e;
                if (b_exp_q.size() == 0) begin
                    check("b_unexpected_send", 1, 0);
                end else begin
                    e = b_exp_q.pop_front();
                    check("b_unit", int'(b_unit), int'(e[15:8]));
                    check("b_code", int'(b_code), int'(e[7:0]));
                end
                b_hold = 1;
            end else if (b_send) begin
                b_hold++;
            end
            if (!b_send && b_send_q) begin
                check("b_send_hold", b_hold, 3);
                b_fall_cyc = cyc;
                b_fall_seen = 1'b1;
            end
            if (b_in_ready && !b_rdy_q && b_fall_seen) begin
                check("b_ready_after_send", cyc - b_fall_cyc, 2);
                b_fall_seen = 1'b0;
            end
            if (in_write(b_dbg_state) && in_write(b_state_q)) begin
                check("b_unit_stable", int'(b_unit), int'(b_unit_q));
                check("b_code_stable", int'(b_code), int'(b_code_q));
            end
            if (b_done) b_done_cnt++;
        end
        b_send_q  = b_send;
        b_rdy_q   = b_in_ready;
        b_state_q = b_dbg_state;
        b_unit_q  = b_unit;
        b_code_q  = b_code;
    end

    // ---------------- driver tasks
    task automatic do_start(input logic [7:0] b, input logic [7:0] l, input logic a);
        @(posedge clk); #1;
        start = 1'b1; base = b; len = l; auto_run = a;
        @(posedge clk); #1;
        start = 1'b0;
        exp_unit = b;
    endtask

    task automatic send_byte(input logic [7:0] d, input int delay);
        logic got;
        if (delay > 0) begin
            repeat (delay) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data = d;
        exp_q.push_back({exp_unit, d});
        exp_unit = exp_unit + 8'd1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) check("handshake_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (!busy) got = 1'b1;
        end
        if (!got) check("idle_timeout", 0, 1);
    endtask

    task automatic b_wait_ready();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (b_in_ready) got = 1'b1;
        end
        if (!got) check("b_handshake_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence
    initial begin
        int d0, e0, r0, s0;
        logic got;
        rst = 1'b1;
        start = 1'b0; base = 8'd0; len = 8'd0; auto_run = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_data = 8'd0; exp_unit = 8'd0;
        b_start = 1'b0; b_base = 8'd0; b_len = 8'd0; b_auto_run = 1'b0; b_abort = 1'b0;
        b_in_valid = 1'b0; b_in_data = 8'd0;

        repeat (3) @(negedge clk);
        check("rst_edit", int'(edit), 0);
        check("rst_send", int'(send), 0);
        check("rst_unit", int'(unit), 0);
        check("rst_code", int'(code), 0);
        check("rst_run", int'(run), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Two bytes back to back, auto_run set.
        d0 = done_cnt;
        do_start(8'h01, 8'd2, 1'b1);
        send_byte(8'h10, 0);
        send_byte(8'h30, 0);
        wait_idle(50);
        check("b2b_done_pulses", done_cnt - d0, 1);
        check("b2b_run", int'(run), 1);
        check("b2b_period", last_rise - prev_rise, 4);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Zero-length load finishes at once and drops run.
        d0 = done_cnt; e0 = edit_cnt; r0 = rdy_cnt; s0 = rises;
        @(posedge clk); #1;
        start = 1'b1; base = 8'h09; len = 8'd0; auto_run = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("len0_done_next", int'(done), 1);
        wait_idle(5);
        check("len0_done_pulses", done_cnt - d0, 1);
        check("len0_edit", edit_cnt - e0, 0);
        check("len0_in_ready", rdy_cnt - r0, 0);
        check("len0_send", rises - s0, 0);
        check("len0_run", int'(run), 0);

        // Unit address wraps past FF; slow source.
        d0 = done_cnt;
        do_start(8'hFE, 8'd3, 1'b1);
        send_byte(8'h11, 5);
        send_byte(8'h22, 5);
        send_byte(8'h33, 5);
        wait_idle(50);
        check("wrap_done_pulses", done_cnt - d0, 1);
        check("wrap_run", int'(run), 1);
        check("wrap_queue_empty", exp_q.size(), 0);

        // Abort during the strobe of the second of four bytes.
        d0 = done_cnt;
        do_start(8'h20, 8'd4, 1'b1);
        check("abort_run_cleared", int'(run), 0);
        send_byte(8'hA1, 0);
        send_byte(8'hA2, 0);
        @(posedge clk); #1;
        check("abort_in_strobe", int'(send), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_edit", int'(edit), 0);
        check("abort_send", int'(send), 0);
        check("abort_busy", int'(busy), 0);
        repeat (4) @(posedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_run", int'(run), 0);
        check("abort_queue_empty", exp_q.size(), 0);
        d0 = done_cnt;
        do_start(8'h50, 8'd1, 1'b1);
        send_byte(8'h5A, 0);
        wait_idle(50);
        check("post_abort_done", done_cnt - d0, 1);
        check("post_abort_run", int'(run), 1);

        // Start pulsed mid-load is ignored.
        d0 = done_cnt;
        do_start(8'h60, 8'd3, 1'b0);
        send_byte(8'hB1, 0);
        start = 1'b1; base = 8'h40; len = 8'd5; auto_run = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; base = 8'h00; len = 8'd0; auto_run = 1'b0;
        send_byte(8'hB2, 0);
        send_byte(8'hB3, 0);
        wait_idle(50);
        check("restart_done_pulses", done_cnt - d0, 1);
        check("restart_run", int'(run), 0);
        check("restart_queue_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of a load.
        d0 = done_cnt;
        do_start(8'h70, 8'd2, 1'b1);
        send_byte(8'hC1, 0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_edit", int'(edit), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_unit", int'(unit), 0);
        check("midrst_code", int'(code), 0);
        check("midrst_run", int'(run), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_queue_empty", exp_q.size(), 0);

        // Longer strobe and gap on the second instance.
        @(posedge clk); #1;
        b_start = 1'b1; b_base = 8'h05; b_len = 8'd2; b_auto_run = 1'b0;
        @(posedge clk); #1;
        b_start = 1'b0;
        b_in_valid = 1'b1; b_in_data = 8'hC3;
        b_exp_q.push_back({8'h05, 8'hC3});
        b_wait_ready();
        b_in_data = 8'hD4;
        b_exp_q.push_back({8'h06, 8'hD4});
        b_wait_ready();
        b_in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (!b_busy) got = 1'b1;
        end
        if (!got) check("b_idle_timeout", 0, 1);
        check("b_done_pulses", b_done_cnt, 1);
        check("b_run", int'(b_run), 0);
        check("b_queue_empty", b_exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
